// File: rtl/edge_event_arbiter_if.sv
// Event handshake between the edge event arbiter and its single consumer.
// The arbiter drives the event fields; the consumer answers with evt_ready.
interface edge_event_arbiter_if #(
  parameter int CHW = 2
);
  logic           evt_valid;
  logic           evt_ready;
  logic [CHW-1:0] evt_channel;
  logic           evt_rising;
  logic           evt_level;

  modport master (
    output evt_valid,
    output evt_channel,
    output evt_rising,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_channel,
    input  evt_rising,
    input  evt_level,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Holds conditioner edge pulses as per-channel pending events and serves them
// round-robin to one consumer over valid/ready, flagging lost events as overflow.
//
//   state   | meaning
//   EMPTY   | no event presented, evt_valid = 0
//   PRESENT | event on the outputs, held stable until evt_ready
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CHW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     pos_pulse,
  input  logic [NUM_CH-1:0]     neg_pulse,
  input  logic [NUM_CH-1:0]     level_in,
  input  logic                  overflow_clr,
  output logic [NUM_CH-1:0]     overflow,
  edge_event_arbiter_if.master  ev
);

  localparam logic [0:0] EMPTY   = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]        out_st;
  logic [NUM_CH-1:0] pend, pend_rise, pend_lvl;
  logic [CHW-1:0]    ptr, ptr_nxt, gnt_ch, hi_ch, any_ch;
  logic              hi_found, any_found, load, gnt_rise, gnt_lvl;
  logic [NUM_CH-1:0] hit, granted, take, ovf_set;

  assign ev.evt_valid = (out_st == PRESENT);

  // Rotated priority: lowest pending channel at or above ptr, else lowest overall.
  always_comb begin
    hi_found  = 1'b0;
    any_found = 1'b0;
    hi_ch     = '0;
    any_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        any_found = 1'b1;
        any_ch    = CHW'(c);
        if (c >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_ch    = CHW'(c);
        end
      end
    end
    gnt_ch  = hi_found ? hi_ch : any_ch;
    load    = any_found && ((out_st == EMPTY) || ev.evt_ready);
    ptr_nxt = (gnt_ch == CHW'(NUM_CH - 1)) ? '0 : gnt_ch + CHW'(1);
    gnt_rise = 1'b0;
    gnt_lvl  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_ch == CHW'(c)) begin
        gnt_rise = pend_rise[c];
        gnt_lvl  = pend_lvl[c];
      end
    end
  end

  // A slot being granted this edge can take a new pulse without loss.
  always_comb begin
    hit     = '0;
    granted = '0;
    take    = '0;
    ovf_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c]     = pos_pulse[c] || neg_pulse[c];
      granted[c] = load && (gnt_ch == CHW'(c));
      take[c]    = hit[c] && (!pend[c] || granted[c]);
      ovf_set[c] = hit[c] && ((pend[c] && !granted[c]) || (pos_pulse[c] && neg_pulse[c]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_st         <= EMPTY;
      ev.evt_channel <= '0;
      ev.evt_rising  <= 1'b0;
      ev.evt_level   <= 1'b0;
      ptr            <= '0;
      pend           <= '0;
      pend_rise      <= '0;
      pend_lvl       <= '0;
      overflow       <= '0;
    end else begin
      if (load) begin
        out_st         <= PRESENT;
        ev.evt_channel <= gnt_ch;
        ev.evt_rising  <= gnt_rise;
        ev.evt_level   <= gnt_lvl;
        ptr            <= ptr_nxt;
      end else if ((out_st == PRESENT) && ev.evt_ready) begin
        out_st <= EMPTY;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (take[c]) begin
          pend[c]      <= 1'b1;
          pend_rise[c] <= pos_pulse[c];
          pend_lvl[c]  <= level_in[c];
        end else if (granted[c]) begin
          pend[c] <= 1'b0;
        end
      end
      // Set wins over a simultaneous clear.
      overflow <= (overflow & ~{NUM_CH{overflow_clr}}) | ovf_set;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: expected events are queued as pulses
// are driven and popped by a monitor on every completed handshake.
module tb_edge_event_arbiter;
  localparam int NUM_CH = 4;
  localparam int CHW    = 2;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] pos_pulse, neg_pulse, level_in, overflow;
  logic              overflow_clr;

  edge_event_arbiter_if #(.CHW(CHW)) ev ();

  edge_event_arbiter #(.NUM_CH(NUM_CH), .CHW(CHW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pos_pulse    (pos_pulse),
    .neg_pulse    (neg_pulse),
    .level_in     (level_in),
    .overflow_clr (overflow_clr),
    .overflow     (overflow),
    .ev           (ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [CHW+1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] n);
    pos_pulse = p;
    neg_pulse = n;
    step();
    pos_pulse = '0;
    neg_pulse = '0;
  endtask

  task automatic push(input int ch, input logic rise, input logic lvl);
    sb_q.push_back({CHW'(ch), rise, lvl});
  endtask

  task automatic wait_drain(input string tag, input int max_cyc, output int n);
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: a handshake completes at the next posedge.
  always @(negedge clk) begin
    if (!reset && ev.evt_valid && ev.evt_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [CHW+1:0] exp_evt;
        exp_evt = sb_q.pop_front();
        check("evt", 32'({ev.evt_channel, ev.evt_rising, ev.evt_level}), 32'(exp_evt));
      end
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    pos_pulse    = '0;
    neg_pulse    = '0;
    level_in     = '0;
    overflow_clr = 1'b0;
    ev.evt_ready = 1'b0;
    @(negedge clk);
    check("rst_valid",   32'(ev.evt_valid),   32'd0);
    check("rst_channel", 32'(ev.evt_channel), 32'd0);
    check("rst_rising",  32'(ev.evt_rising),  32'd0);
    check("rst_level",   32'(ev.evt_level),   32'd0);
    check("rst_ovf",     32'(overflow),       32'd0);
    step();
    reset = 1'b0;

    // 1: single rising event on ch2, two-cycle latency, one cycle valid
    ev.evt_ready = 1'b1;
    level_in = 4'b0100;
    push(2, 1'b1, 1'b1);
    drive_pulse(4'b0100, 4'b0000);
    @(negedge clk);
    check("t1_not_yet", 32'(ev.evt_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_valid", 32'(ev.evt_valid), 32'd1);
    step();
    @(negedge clk);
    check("t1_one_cycle", 32'(ev.evt_valid), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_drained", 32'(sb_q.size()), 32'd0);
    step();

    // 2: round robin from ptr=0, then from ptr=2
    do_reset();
    level_in = 4'b1010;
    push(0, 1'b1, 1'b0);
    push(1, 1'b1, 1'b1);
    push(3, 1'b1, 1'b1);
    drive_pulse(4'b1011, 4'b0000);
    wait_drain("t2a_drain", 20, n);
    check("t2a_back_to_back", 32'(n), 32'd4);
    push(1, 1'b1, 1'b1);
    drive_pulse(4'b0010, 4'b0000);
    wait_drain("t2b_drain", 20, n);
    push(3, 1'b1, 1'b1);
    push(0, 1'b1, 1'b0);
    push(1, 1'b1, 1'b1);
    drive_pulse(4'b1011, 4'b0000);
    wait_drain("t2c_drain", 20, n);
    check("t2c_back_to_back", 32'(n), 32'd4);

    // 3: stalled consumer, slot refill after move to output, then overflow
    ev.evt_ready = 1'b0;
    level_in = 4'b0010;
    push(1, 1'b1, 1'b1);
    drive_pulse(4'b0010, 4'b0000);
    step();
    @(negedge clk);
    check("t3_hold", 32'({ev.evt_valid, ev.evt_channel, ev.evt_rising, ev.evt_level}), 32'b1_01_1_1);
    step();
    level_in = 4'b0000;
    push(1, 1'b0, 1'b0);
    drive_pulse(4'b0000, 4'b0010);
    @(negedge clk);
    check("t3_neg_kept", 32'(overflow), 32'd0);
    step();
    drive_pulse(4'b0010, 4'b0000);
    @(negedge clk);
    check("t3_ovf", 32'(overflow), 32'b0010);
    check("t3_stable", 32'({ev.evt_valid, ev.evt_channel, ev.evt_rising, ev.evt_level}), 32'b1_01_1_1);
    step();
    ev.evt_ready = 1'b1;
    wait_drain("t3_drain", 20, n);
    @(negedge clk);
    check("t3_empty", 32'(ev.evt_valid), 32'd0);
    step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    @(negedge clk);
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    step();

    // 4: pulse arrives on the edge its channel is granted
    level_in = 4'b0001;
    push(0, 1'b1, 1'b1);
    drive_pulse(4'b0001, 4'b0000);
    level_in = 4'b0000;
    push(0, 1'b0, 1'b0);
    drive_pulse(4'b0000, 4'b0001);
    @(negedge clk);
    check("t4_valid", 32'(ev.evt_valid), 32'd1);
    wait_drain("t4_drain", 20, n);
    check("t4_no_ovf", 32'(overflow), 32'd0);

    // 5: set wins over simultaneous clear
    ev.evt_ready = 1'b0;
    level_in = 4'b0101;
    push(0, 1'b1, 1'b1);
    drive_pulse(4'b0001, 4'b0001);
    push(2, 1'b1, 1'b1);
    drive_pulse(4'b0100, 4'b0000);
    @(negedge clk);
    check("t5_ovf_both", 32'(overflow), 32'b0001);
    step();
    overflow_clr = 1'b1;
    drive_pulse(4'b0100, 4'b0000);
    overflow_clr = 1'b0;
    @(negedge clk);
    check("t5_set_wins", 32'(overflow), 32'b0100);
    step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    @(negedge clk);
    check("t5_clr", 32'(overflow), 32'd0);
    step();
    ev.evt_ready = 1'b1;
    wait_drain("t5_drain", 20, n);

    // 6: async reset mid-handshake with events pending
    ev.evt_ready = 1'b0;
    level_in = 4'b1111;
    drive_pulse(4'b1111, 4'b0000);
    step();
    @(negedge clk);
    check("t6_valid_before", 32'(ev.evt_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_async", 32'(ev.evt_valid), 32'd0);
    check("t6_chan_async", 32'(ev.evt_channel), 32'd0);
    check("t6_ovf_async", 32'(overflow), 32'd0);
    step();
    reset = 1'b0;
    ev.evt_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("t6_no_events", 32'(ev.evt_valid), 32'd0);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Collects the one-cycle positiveedge/negativeedge pulses from NUM_CH input conditioner instances (buttons/switches) and holds each as a pending event. Serves the pending events one at a time to a single downstream consumer (command decoder / shift-register loader) over a valid/ready handshake, using round-robin arbitration. Any event the consumer cannot drain in time is reported on a sticky per-channel overflow flag.

Parameters:
NUM_CH, 4, number of conditioned input channels (2..16)
CHW, 2, width of channel index, ≥ ceil(log2(NUM_CH))

Ports:
clk  input  1  system clock; all conditioners share this domain
reset  input  1  asynchronous, active-high reset
pos_pulse  input  NUM_CH  per-channel positiveedge pulses, 1 clk wide
neg_pulse  input  NUM_CH  per-channel negativeedge pulses, 1 clk wide
level_in  input  NUM_CH  per-channel conditioned level
evt_valid  output  1  event presented to consumer
evt_ready  input  1  consumer accepts the event this cycle
evt_channel  output  CHW  channel index of the presented event
evt_rising  output  1  1 = rising edge event, 0 = falling edge event
evt_level  output  1  level_in[channel] sampled when the event was captured
overflow  output  NUM_CH  sticky per-channel lost-event flags
overflow_clr  input  1  one-cycle pulse; clears all overflow bits

Behaviour:
- Reset (async, immediate): evt_valid=0, evt_channel=0, evt_rising=0, evt_level=0, overflow=0, all pending bits=0, round-robin pointer=0. Reset mid-handshake discards the presented event and all pending events.
- Per-channel pending slot: pend[c], pend_rise[c], pend_lvl[c].
- Capture: at a clk edge where pos_pulse[c] or neg_pulse[c] is 1:
  - pend[c]=0, or pend[c] is being granted this same edge: pend[c]<=1, pend_rise[c]<=pos_pulse[c], pend_lvl[c]<=level_in[c].
  - pend[c]=1 and not granted this edge: the new pulse is dropped, the slot keeps the oldest event, overflow[c]<=1.
  - pos_pulse[c] and neg_pulse[c] both 1 in the same cycle (illegal from a conditioner): capture as rising and set overflow[c].
- Output register states:
  - EMPTY (evt_valid=0).
  - PRESENT (evt_valid=1). Outputs stay stable while evt_valid && !evt_ready.
- Load condition: output loads at an edge where (EMPTY or evt_ready=1) and any pend=1. Gives back-to-back throughput of one event per cycle under constant evt_ready.
- No load at that edge: if PRESENT and evt_ready=1, go to EMPTY.
- Grant:
  - Search order starts at the pointer: ptr, ptr+1, …, NUM_CH-1, 0, … (wraps mod NUM_CH).
  - First channel c with pend[c]=1 is granted. Its slot is moved to the output and pend[c] is cleared.
  - ptr <= (c+1) mod NUM_CH. ptr is unchanged when there is no grant.
- Latency:
  - Pulse high in cycle k (sampled at edge k): pending at edge k.
  - Earliest evt_valid is after edge k+1, i.e. 2 clk from pulse to valid.
  - Same-cycle bypass is not provided.
- Pending reads in the grant search use the registered pend values (pre-capture). A pulse arriving the same edge as a grant on the same channel refills the slot with no overflow.
- overflow bits are sticky. overflow_clr clears them, except that a bit being set in the same cycle stays 1 (set wins).
- Width rules:
  - Pointer arithmetic wraps at NUM_CH, not 2^CHW, for non-power-of-two NUM_CH.
  - evt_channel is zero-extended to CHW.
- evt_ready while EMPTY has no effect.

Test Plan:
1. Reset then pos_pulse[2] for 1 cycle, evt_ready=1 → evt_valid=1 two cycles later with channel=2, rising=1, level=1, for exactly 1 cycle; overflow=0.
2. Same-cycle pos_pulse on channels 0, 1, 3 with evt_ready=1, ptr=0 → events 0, 1, 3 on consecutive cycles; ptr then =0. Repeat with ptr preset to 2 (grant ch1 first) → order 3, 0, 1.
3. evt_ready=0 and pulses on ch1: pos, then neg 3 cycles later → evt_valid holds ch1/rising stable; the neg pulse is not dropped (slot free after move to output); a third pulse (pos) sets overflow[1]=1. Raise evt_ready → rising, then falling delivered, then EMPTY.
4. Pulse on ch0 in the same cycle ch0 is granted → no overflow; second ch0 event delivered next.
5. overflow_clr asserted in the same cycle a new overflow on ch2 occurs → overflow[2] stays 1, all others cleared; next overflow_clr alone → all 0.
6. Assert reset asynchronously (between edges) while evt_valid=1 and 3 events pending → outputs drop immediately; after release, no events appear with no further pulses.
